// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter: instruction-fetch (I) and load/store (D) masters
// share one bus; ownership is locked while the owner requests, round robin on contention.
module bus_arbiter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] i_adr_i,
    input  logic [1:0]  i_size_i,
    output logic        i_ack_o,
    output logic [15:0] i_dat_o,
    input  logic [63:0] d_adr_i,
    input  logic [1:0]  d_size_i,
    input  logic        d_we_i,
    input  logic [15:0] d_dat_i,
    output logic        d_ack_o,
    output logic [15:0] d_dat_o,
    output logic [63:0] adr_o,
    output logic [1:0]  size_o,
    output logic        we_o,
    output logic [15:0] dat_o,
    input  logic [15:0] dat_i,
    input  logic        ack_i,
    output logic [1:0]  gnt_o
);

    localparam int unsigned ADR_W  = 64;
    localparam int unsigned DAT_W  = 16;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned GNT_W  = 2;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   w_i_req;
    logic   w_d_req;

    assign w_i_req = (i_size_i != SIZE_W'(0));
    assign w_d_req = (d_size_i != SIZE_W'(0));

    // State and last-owner registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_last  <= LAST_D;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state: owner keeps the bus while requesting, hands off directly on release
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_state_nxt = (r_last == LAST_I) ? OWN_D : OWN_I;
                end else if (w_i_req) begin
                    w_state_nxt = OWN_I;
                end else if (w_d_req) begin
                    w_state_nxt = OWN_D;
                end
            end
            OWN_I: begin
                if (!w_i_req) begin
                    w_last_nxt  = LAST_I;
                    w_state_nxt = w_d_req ? OWN_D : IDLE;
                end
            end
            OWN_D: begin
                if (!w_d_req) begin
                    w_last_nxt  = LAST_D;
                    w_state_nxt = w_i_req ? OWN_I : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus mux and acknowledge steering from the current owner
    always_comb begin
        adr_o   = ADR_W'(0);
        size_o  = SIZE_W'(0);
        we_o    = 1'b0;
        dat_o   = DAT_W'(0);
        i_ack_o = 1'b0;
        d_ack_o = 1'b0;
        gnt_o   = GNT_W'(0);
        case (r_state)
            OWN_I: begin
                adr_o   = i_adr_i;
                size_o  = i_size_i;
                i_ack_o = ack_i;
                gnt_o   = 2'b01;
            end
            OWN_D: begin
                adr_o   = d_adr_i;
                size_o  = d_size_i;
                we_o    = d_we_i;
                dat_o   = d_dat_i;
                d_ack_o = ack_i;
                gnt_o   = 2'b10;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own ack
    assign i_dat_o = dat_i;
    assign d_dat_o = dat_i;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios then randomized traffic,
// every cycle compared against an owner/last-owner reference model.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [63:0] i_adr_i;
    logic [1:0]  i_size_i;
    logic        i_ack_o;
    logic [15:0] i_dat_o;
    logic [63:0] d_adr_i;
    logic [1:0]  d_size_i;
    logic        d_we_i;
    logic [15:0] d_dat_i;
    logic        d_ack_o;
    logic [15:0] d_dat_o;
    logic [63:0] adr_o;
    logic [1:0]  size_o;
    logic        we_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        ack_i;
    logic [1:0]  gnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: owner 0 = none, 1 = I, 2 = D; last owner 1 = I, 2 = D
    int m_own  = 0;
    int m_last = 2;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .i_adr_i  (i_adr_i),
        .i_size_i (i_size_i),
        .i_ack_o  (i_ack_o),
        .i_dat_o  (i_dat_o),
        .d_adr_i  (d_adr_i),
        .d_size_i (d_size_i),
        .d_we_i   (d_we_i),
        .d_dat_i  (d_dat_i),
        .d_ack_o  (d_ack_o),
        .d_dat_o  (d_dat_o),
        .adr_o    (adr_o),
        .size_o   (size_o),
        .we_o     (we_o),
        .dat_o    (dat_o),
        .dat_i    (dat_i),
        .ack_i    (ack_i),
        .gnt_o    (gnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset_i) begin
            m_own  = 0;
            m_last = 2;
        end else if (m_own == 0) begin
            if (i_size_i != 0 && d_size_i != 0) m_own = (m_last == 1) ? 2 : 1;
            else if (i_size_i != 0)              m_own = 1;
            else if (d_size_i != 0)              m_own = 2;
        end else if (m_own == 1) begin
            if (i_size_i == 0) begin
                m_last = 1;
                m_own  = (d_size_i != 0) ? 2 : 0;
            end
        end else begin
            if (d_size_i == 0) begin
                m_last = 2;
                m_own  = (i_size_i != 0) ? 1 : 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] e_adr;
        logic [1:0]  e_size;
        logic        e_we;
        logic [15:0] e_dat;
        logic [1:0]  e_gnt;
        e_adr  = (m_own == 1) ? i_adr_i  : (m_own == 2) ? d_adr_i  : 64'd0;
        e_size = (m_own == 1) ? i_size_i : (m_own == 2) ? d_size_i : 2'd0;
        e_we   = (m_own == 2) ? d_we_i : 1'b0;
        e_dat  = (m_own == 2) ? d_dat_i : 16'd0;
        e_gnt  = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        check("gnt",   64'(gnt_o),   64'(e_gnt));
        check("size",  64'(size_o),  64'(e_size));
        check("adr",   adr_o,        e_adr);
        check("we",    64'(we_o),    64'(e_we));
        check("dat_o", 64'(dat_o),   64'(e_dat));
        check("i_ack", 64'(i_ack_o), 64'((m_own == 1) && ack_i));
        check("d_ack", 64'(d_ack_o), 64'((m_own == 2) && ack_i));
        check("i_dat", 64'(i_dat_o), 64'(dat_i));
        check("d_dat", 64'(d_dat_o), 64'(dat_i));
    endtask

    // One cycle: settle, compare against model, clock, advance model
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset_i  = 1'b1;
        i_adr_i  = 64'd0;
        i_size_i = 2'd2;
        d_adr_i  = 64'h0000_0000_0000_1000;
        d_size_i = 2'd2;
        d_we_i   = 1'b0;
        d_dat_i  = 16'd0;
        dat_i    = 16'd0;
        ack_i    = 1'b0;
        @(posedge clk);
        model_edge();
        #1;

        // Reset held two cycles with both masters requesting
        tick();
        tick();
        reset_i = 1'b0;
        i_adr_i = 64'hFFFF_FFFF_FFFF_FF00;
        tick();
        check("rst_rel_gnt", 64'(gnt_o), 64'h1);
        check("rst_rel_adr", adr_o, 64'hFFFF_FFFF_FFFF_FF00);

        // Fetch alone, acked every cycle
        d_size_i = 2'd0;
        ack_i    = 1'b1;
        dat_i    = 16'hAAAA;
        tick();
        tick();
        i_adr_i = 64'hFFFF_FFFF_FFFF_FF02;
        dat_i   = 16'hBBBB;
        tick();
        check("fetch_iack", 64'(i_ack_o), 64'h1);
        check("fetch_dack", 64'(d_ack_o), 64'h0);
        tick();
        i_size_i = 2'd0;
        tick();
        check("fetch_idle", 64'(gnt_o), 64'h0);

        // Contention: D waits while I holds, then takes over without an idle gap
        i_size_i = 2'd2;
        tick();
        d_size_i = 2'd1;
        d_we_i   = 1'b1;
        d_dat_i  = 16'h1234;
        tick();
        tick();
        check("cont_dwait", 64'(d_ack_o), 64'h0);
        i_size_i = 2'd0;
        tick();
        check("cont_gnt", 64'(gnt_o), 64'h2);
        check("cont_we",  64'(we_o),  64'h1);
        check("cont_dat", 64'(dat_o), 64'h1234);

        // Round robin: last owner D -> I wins, then last owner I -> D wins
        d_size_i = 2'd0;
        tick();
        i_size_i = 2'd3;
        d_size_i = 2'd3;
        tick();
        check("rr_to_i", 64'(gnt_o), 64'h1);
        i_size_i = 2'd0;
        d_size_i = 2'd0;
        tick();
        i_size_i = 2'd3;
        d_size_i = 2'd3;
        tick();
        check("rr_to_d", 64'(gnt_o), 64'h2);

        // Stray ack while idle
        i_size_i = 2'd0;
        d_size_i = 2'd0;
        ack_i    = 1'b0;
        tick();
        ack_i = 1'b1;
        #1;
        check("stray_iack", 64'(i_ack_o), 64'h0);
        check("stray_dack", 64'(d_ack_o), 64'h0);
        tick();

        // Reset during OWN_D with ack asserted
        d_size_i = 2'd1;
        tick();
        check("own_d_ack", 64'(d_ack_o), 64'h1);
        reset_i = 1'b1;
        tick();
        check("rst_dack", 64'(d_ack_o), 64'h0);
        check("rst_gnt",  64'(gnt_o),   64'h0);
        reset_i = 1'b0;
        tick();

        // Randomized traffic; sizes tend to persist so locks and handoffs occur
        for (int n = 0; n < 3000; n++) begin
            reset_i = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0)
                i_size_i = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0)
                d_size_i = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            i_adr_i = {$urandom, $urandom};
            d_adr_i = {$urandom, $urandom};
            d_we_i  = 1'($urandom_range(0, 1));
            d_dat_i = 16'($urandom);
            dat_i   = 16'($urandom);
            ack_i   = 1'($urandom_range(0, 1));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk_i  in  1  sole clock; all state changes on rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 i_adr_i  in  64  instruction-fetch master address.
REQ-005 i_size_i  in  2  fetch request size (0 idle, 1 byte, 2 halfword, 3 word).
REQ-006 i_ack_o  out  1  fetch-master acknowledge.
REQ-007 i_dat_o  out  16  read data to fetch master.
REQ-008 d_adr_i  in  64  load/store master address.
REQ-009 d_size_i  in  2  load/store request size, same encoding as i_size_i.
REQ-010 d_we_i  in  1  load/store write enable.
REQ-011 d_dat_i  in  16  load/store write data.
REQ-012 d_ack_o  out  1  load/store master acknowledge.
REQ-013 d_dat_o  out  16  read data to load/store master.
REQ-014 adr_o  out  64  shared bus address.
REQ-015 size_o  out  2  shared bus size; 0 means the bus is idle.
REQ-016 we_o  out  1  shared bus write enable.
REQ-017 dat_o  out  16  shared bus write data.
REQ-018 dat_i  in  16  shared bus read data.
REQ-019 ack_i  in  1  shared bus acknowledge.
REQ-020 gnt_o  out  2  current owner, one-hot: 01 = I, 10 = D, 00 = none.

Function
REQ-021 The state machine SHALL have exactly three states: IDLE, OWN_I, OWN_D; a 1-bit last-owner register SHALL record the most recent owner (0 = I, 1 = D).
REQ-022 A master requests the bus whenever its size input is nonzero.
- IDLE, no request: stay in IDLE.
- IDLE, one request: go to that master's OWN state.
- IDLE, both requesting: grant the master that is not last-owner (round robin).
REQ-023 In OWN_x, while x_size_i != 0 the arbiter SHALL remain in OWN_x (lock); a multi-beat fetch is never split.
REQ-024 In OWN_x with x_size_i == 0, the next state SHALL be:
- OWN of the other master if it is requesting;
- otherwise IDLE.
- last-owner SHALL update to x on that edge.
REQ-025 Bus outputs SHALL be combinational muxes of the owner's inputs in OWN_x; in IDLE: size_o = 0, we_o = 0, adr_o = 0, dat_o = 0.
REQ-026 In OWN_I, we_o SHALL be 0 regardless of d_we_i.
REQ-027 Acknowledges:
- x_ack_o = ack_i only while in OWN_x, with zero added latency;
- the non-owner's ack SHALL be 0;
- ack_i while in IDLE SHALL be ignored.
REQ-028 i_dat_o and d_dat_o SHALL both equal dat_i at all times; masters qualify the data with their own ack.
REQ-029 Grant latency SHALL be exactly one cycle from a request seen in IDLE to the owner's request appearing on size_o; handoff between masters SHALL take one cycle of the releasing master's size == 0, with no intervening IDLE cycle.
REQ-030 A request withdrawn (size 0) before its grant takes effect SHALL cause no bus cycle; the arbiter re-evaluates each edge.
REQ-031 gnt_o SHALL reflect the current state register.

Reset
REQ-032 While reset_i is high at a rising edge:
- state SHALL become IDLE and last-owner SHALL become D, so the first contended grant after reset goes to I;
- all outputs derived from state SHALL be idle (size_o = 0, gnt_o = 00, i_ack_o = d_ack_o = 0).
REQ-033 Reset asserted mid-transfer SHALL abort ownership at that edge, with no further ack passed to either master; requests are re-arbitrated from IDLE after release.

Verification
REQ-034 Reset for 2 cycles with both sizes = 2 -> size_o = 0 and gnt_o = 00 during reset; 1 cycle after release gnt_o = 01 and adr_o = i_adr_i.
REQ-035 Fetch alone: i_size_i = 2 for 4 cycles, i_adr_i = FFFFFFFFFFFFFF00 then ...02, ack_i = 1, dat_i = AAAA/BBBB -> i_ack_o follows ack_i and d_ack_o = 0 throughout; state stays OWN_I until i_size_i = 0.
REQ-036 Contention: D requests (size 1, we 1, dat 1234) while I holds the bus -> D waits with d_ack_o = 0; on the first cycle I drops size, the next edge gives gnt_o = 10, we_o = 1, dat_o = 1234, with no IDLE gap.
REQ-037 Round robin: both requesting in IDLE with last-owner = I -> D granted; repeat with last-owner = D -> I granted.
REQ-038 Stray ack_i = 1 in IDLE -> i_ack_o = d_ack_o = 0. Reset asserted during OWN_D with ack_i = 1 -> d_ack_o = 0 the cycle after reset, and state = IDLE.
